bcd_run_counter: RTL



---
 rtl/bcd_run_pkg.sv | 16 +
 rtl/button_debounce.sv | 42 ++++
 rtl/bcd_run_counter.sv | 95 +++++++++
 3 files changed

// File: rtl/bcd_run_pkg.sv
// Shared types and constants for the single-digit BCD run/stop counter.
package bcd_run_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Prescaler register width; a divide of 2 still needs one bit.
    function automatic int presc_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter,
// and a one-cycle pulse on an accepted press (never on release).
module button_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The flip happens on the DEB_CYCLES-th consecutive differing sample,
    // so the counter only ever needs to reach DEB_CYCLES-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync[1];
                pulse <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_run_counter.sv
// Run/stop decimal digit: debounced start/clear buttons, prescaler,
// 0..9 BCD register with a one-cycle carry on the 9->0 wrap.
module bcd_run_counter #(
    parameter int DIV        = 50_000_000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PSW_START,
    input  logic       PSW_CLR,
    output logic [3:0] BCD,
    output logic       CARRY,
    output logic       RUN
);

    import bcd_run_pkg::*;

    localparam int PW = presc_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic [1:0] btn_level_unused;
    logic       start_p;
    logic       clr_p;

    assign btn_raw = {PSW_CLR, PSW_START};
    assign start_p = btn_pulse[0];
    assign clr_p   = btn_pulse[1];

    for (genvar g = 0; g < 2; g++) begin : g_btn
        button_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (btn_raw[g]),
            .pulse(btn_pulse[g]),
            .level(btn_level_unused[g])
        );
    end

    run_state_e    state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    bcd_nxt;
    logic          carry_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= bcd_run_pkg::STOP;
            presc <= '0;
            BCD   <= '0;
            CARRY <= 1'b0;
            RUN   <= 1'b0;
        end else begin
            state <= state_nxt;
            presc <= presc_nxt;
            BCD   <= bcd_nxt;
            CARRY <= carry_nxt;
            RUN   <= (state_nxt == bcd_run_pkg::RUN);
        end
    end

    // Counting follows the current state, so the edge that stops a run
    // still advances the prescaler; clear overrides everything.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        bcd_nxt   = BCD;
        carry_nxt = 1'b0;
        if (clr_p) begin
            state_nxt = bcd_run_pkg::STOP;
            presc_nxt = '0;
            bcd_nxt   = '0;
        end else begin
            if (start_p)
                state_nxt = (state == bcd_run_pkg::RUN) ? bcd_run_pkg::STOP
                                                        : bcd_run_pkg::RUN;
            if (state == bcd_run_pkg::RUN) begin
                if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    if (BCD >= BCD_MAX) begin
                        bcd_nxt   = '0;
                        carry_nxt = 1'b1;
                    end else begin
                        bcd_nxt = BCD + 4'd1;
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
        end
    end

endmodule
